mem_access_stage: RTL and testbench

- MEM-stage controller between the EX/MEM pipeline register and the MEM/WB pipeline register of the 64-bit pipelined CPU.
- Turns LDUR/STUR-class accesses (byte, half, word, double) into a req/ack handshake on a 64-bit data-memory bus.
- Lane-aligns store data and extracts load data.
- Stalls the upstream pipeline while an access is outstanding and inserts bubbles into MEM/WB during the stall.

---
 rtl/mem_access_stage.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage data-memory access controller
//
// Sits between EX/MEM and MEM/WB. Turns load/store requests into a req/ack
// handshake on a 64-bit data bus, lane-aligns store data, extracts and
// zero-extends load data, stalls upstream while an access is outstanding
// and suppresses MEM/WB register writes during the stall.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   MemRead_in, MemWrite_in         load / store request from EX/MEM
//   MemtoReg_in, RegWrite_in, Rd_in writeback control from EX/MEM
//   xfer_size_in                    0=byte 1=half 2=word 3=double
//   alu_result_in                   effective address / ALU result
//   store_data_in                   right-justified store data
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be               data-memory bus request side
//   mem_rdata, mem_ack              data-memory bus response side
//   stall_mem                       freeze PC, IF/ID, ID/EX, EX/MEM
//   MemtoReg_mem, RegWrite_mem,
//   Rd_mem, dm_read_data_mem,
//   alu_result_mem                  to MEM/WB
//   misalign_err, bus_err           one-cycle error pulses

module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic [4:0]  Rd_in,
  input  logic [1:0]  xfer_size_in,
  input  logic [63:0] alu_result_in,
  input  logic [63:0] store_data_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_mem,
  output logic        MemtoReg_mem,
  output logic        RegWrite_mem,
  output logic [4:0]  Rd_mem,
  output logic [63:0] dm_read_data_mem,
  output logic [63:0] alu_result_mem,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] rbuf_q, rbuf_d;
  logic        tout_q, tout_d;   // last access timed out: suppress writeback in DONE

  logic        mem_op, is_store, is_load, misaligned;
  logic [2:0]  offset, size_mask;
  logic [5:0]  bit_shift;
  logic [7:0]  be_lane;
  logic [63:0] rdata_shift, load_data;

  // A simultaneous read+write is handled as a store.
  assign mem_op    = MemRead_in | MemWrite_in;
  assign is_store  = MemWrite_in;
  assign is_load   = MemRead_in & ~MemWrite_in;
  assign offset    = alu_result_in[2:0];
  assign bit_shift = {offset, 3'b000};

  always_comb begin
    size_mask = 3'b000;
    be_lane   = 8'h00;
    load_data = 64'd0;
    case (xfer_size_in)
      2'd0: begin size_mask = 3'b000; be_lane = 8'h01 << offset; load_data = {56'd0, rdata_shift[7:0]};  end
      2'd1: begin size_mask = 3'b001; be_lane = 8'h03 << offset; load_data = {48'd0, rdata_shift[15:0]}; end
      2'd2: begin size_mask = 3'b011; be_lane = 8'h0F << offset; load_data = {32'd0, rdata_shift[31:0]}; end
      default: begin size_mask = 3'b111; be_lane = 8'hFF; load_data = rdata_shift; end
    endcase
  end

  assign misaligned  = |(offset & size_mask);
  assign rdata_shift = mem_rdata >> bit_shift;

  // Address and store data follow EX/MEM directly; the stall holds them stable.
  assign mem_addr       = {alu_result_in[63:3], 3'b000};
  assign mem_wdata      = store_data_in << bit_shift;
  assign MemtoReg_mem   = MemtoReg_in;
  assign Rd_mem         = Rd_in;
  assign alu_result_mem = alu_result_in;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    rbuf_d           = rbuf_q;
    tout_d           = tout_q;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_be           = 8'h00;
    stall_mem        = 1'b0;
    RegWrite_mem     = RegWrite_in;
    dm_read_data_mem = 64'd0;
    misalign_err     = 1'b0;
    bus_err          = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (mem_op) begin
          RegWrite_mem = 1'b0;
          if (misaligned) begin
            misalign_err = 1'b1;
          end else begin
            stall_mem = 1'b1;
            tout_d    = 1'b0;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        mem_req      = 1'b1;
        mem_we       = is_store;
        mem_be       = be_lane;
        stall_mem    = 1'b1;
        RegWrite_mem = 1'b0;
        cnt_d        = cnt_q + 16'd1;
        if (mem_ack) begin
          rbuf_d  = is_load ? load_data : 64'd0;
          tout_d  = 1'b0;
          cnt_d   = 16'd0;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          bus_err = 1'b1;
          rbuf_d  = 64'd0;
          tout_d  = 1'b1;
          cnt_d   = 16'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Always return to IDLE so the still-held instruction is not reissued.
        dm_read_data_mem = rbuf_q;
        RegWrite_mem     = RegWrite_in & ~tout_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_be       = 8'h00;
      stall_mem    = 1'b0;
      RegWrite_mem = 1'b0;
      misalign_err = 1'b0;
      bus_err      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      rbuf_q  <= 64'd0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
      tout_q  <= tout_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in;
  logic [4:0]  Rd_in;
  logic [1:0]  xfer_size_in;
  logic [63:0] alu_result_in, store_data_in;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_be;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        stall_mem, MemtoReg_mem, RegWrite_mem;
  logic [4:0]  Rd_mem;
  logic [63:0] dm_read_data_mem, alu_result_mem;
  logic        misalign_err, bus_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .Rd_in(Rd_in), .xfer_size_in(xfer_size_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_mem(stall_mem), .MemtoReg_mem(MemtoReg_mem),
    .RegWrite_mem(RegWrite_mem), .Rd_mem(Rd_mem),
    .dm_read_data_mem(dm_read_data_mem), .alu_result_mem(alu_result_mem),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  // Advance to just after the next rising edge; inputs are driven there.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    MemRead_in = 0; MemWrite_in = 0; MemtoReg_in = 0; RegWrite_in = 0;
    Rd_in = 0; xfer_size_in = 0; alu_result_in = 0; store_data_in = 0;
    mem_rdata = 0; mem_ack = 0;
  endtask

  task automatic test_reset();
    drive_nop();
    reset = 1; MemRead_in = 1; RegWrite_in = 1; xfer_size_in = 3; alu_result_in = 64'h40;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_mem); end
    checks++; if (RegWrite_mem !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", RegWrite_mem); end
    checks++; if (mem_be !== 8'h00) begin errors++; $display("FAIL reset_be got %h exp 00", mem_be); end
    checks++; if (bus_err !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL reset_errs got %b%b exp 00", bus_err, misalign_err); end
    next_cycle();
    reset = 0; drive_nop();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall_mem !== 1'b0) begin errors++; $display("FAIL post_reset_idle got req=%b stall=%b exp 0 0", mem_req, stall_mem); end
    next_cycle();
  endtask

  task automatic test_alu_passthrough();
    drive_nop();
    RegWrite_in = 1; Rd_in = 5; alu_result_in = 64'h1234; MemtoReg_in = 0;
    @(negedge clk);
    checks++; if (RegWrite_mem !== 1'b1) begin errors++; $display("FAIL add_regwrite got %b exp 1", RegWrite_mem); end
    checks++; if (Rd_mem !== 5'd5) begin errors++; $display("FAIL add_rd got %0d exp 5", Rd_mem); end
    checks++; if (alu_result_mem !== 64'h1234) begin errors++; $display("FAIL add_alu got %h exp 1234", alu_result_mem); end
    checks++; if (stall_mem !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL add_stall got stall=%b req=%b exp 0 0", stall_mem, mem_req); end
    checks++; if (dm_read_data_mem !== 64'd0) begin errors++; $display("FAIL add_dm got %h exp 0", dm_read_data_mem); end
    next_cycle();
  endtask

  task automatic test_load_double();
    int stalls = 0;
    drive_nop();
    MemRead_in = 1; MemtoReg_in = 1; RegWrite_in = 1; Rd_in = 3; xfer_size_in = 3;
    alu_result_in = 64'h100; mem_rdata = 64'hDEADBEEF_CAFEF00D;
    // IDLE cycle then three REQ cycles, ack in the third
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      @(negedge clk);
      if (stall_mem === 1'b1) stalls++;
      checks++; if (RegWrite_mem !== 1'b0) begin errors++; $display("FAIL ld_stall_regwrite cyc %0d got %b exp 0", i, RegWrite_mem); end
      checks++; if (mem_req !== (i != 0)) begin errors++; $display("FAIL ld_req cyc %0d got %b exp %b", i, mem_req, (i != 0)); end
      if (i == 1) begin
        checks++; if (mem_addr !== 64'h100 || mem_be !== 8'hFF || mem_we !== 1'b0) begin
          errors++; $display("FAIL ld_bus got addr=%h be=%h we=%b exp 100 ff 0", mem_addr, mem_be, mem_we); end
      end
      next_cycle();
    end
    mem_ack = 0;
    checks++; if (stalls != 4) begin errors++; $display("FAIL ld_stall_cycles got %0d exp 4", stalls); end
    @(negedge clk);
    checks++; if (dm_read_data_mem !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL ld_data got %h exp deadbeefcafef00d", dm_read_data_mem); end
    checks++; if (RegWrite_mem !== 1'b1 || stall_mem !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL ld_done got rw=%b stall=%b req=%b exp 1 0 0", RegWrite_mem, stall_mem, mem_req); end
    next_cycle();
    drive_nop();
    @(negedge clk);
    checks++; if (stall_mem !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL ld_back_idle got stall=%b req=%b exp 0 0", stall_mem, mem_req); end
    next_cycle();
  endtask

  task automatic test_byte_lanes();
    drive_nop();
    MemWrite_in = 1; xfer_size_in = 0; alu_result_in = 64'h103; store_data_in = 64'hAB;
    @(negedge clk);
    checks++; if (stall_mem !== 1'b1) begin errors++; $display("FAIL sb_idle_stall got %b exp 1", stall_mem); end
    next_cycle();
    mem_ack = 1;
    @(negedge clk);
    checks++; if (mem_be !== 8'h08) begin errors++; $display("FAIL sb_be got %h exp 08", mem_be); end
    checks++; if (mem_wdata !== 64'hAB000000) begin errors++; $display("FAIL sb_wdata got %h exp ab000000", mem_wdata); end
    checks++; if (mem_we !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL sb_we got we=%b req=%b exp 1 1", mem_we, mem_req); end
    next_cycle();
    mem_ack = 0;
    @(negedge clk);
    checks++; if (stall_mem !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL sb_done got stall=%b req=%b exp 0 0", stall_mem, mem_req); end
    next_cycle();
    drive_nop();
    MemRead_in = 1; RegWrite_in = 1; Rd_in = 7; xfer_size_in = 0; alu_result_in = 64'h105;
    mem_rdata = 64'h0000_7700_0000_0000;
    @(negedge clk);
    next_cycle();
    mem_ack = 1;
    @(negedge clk);
    checks++; if (mem_be !== 8'h20 || mem_we !== 1'b0) begin errors++; $display("FAIL lb_be got be=%h we=%b exp 20 0", mem_be, mem_we); end
    next_cycle();
    mem_ack = 0;
    @(negedge clk);
    checks++; if (dm_read_data_mem !== 64'h77) begin errors++; $display("FAIL lb_data got %h exp 77", dm_read_data_mem); end
    checks++; if (RegWrite_mem !== 1'b1) begin errors++; $display("FAIL lb_regwrite got %b exp 1", RegWrite_mem); end
    next_cycle();
    // half store at top lanes, issued with both read and write set
    drive_nop();
    MemRead_in = 1; MemWrite_in = 1; xfer_size_in = 1; alu_result_in = 64'h106; store_data_in = 64'hBEEF;
    @(negedge clk);
    next_cycle();
    mem_ack = 1;
    @(negedge clk);
    checks++; if (mem_be !== 8'hC0 || mem_we !== 1'b1) begin errors++; $display("FAIL sh_be got be=%h we=%b exp c0 1", mem_be, mem_we); end
    checks++; if (mem_wdata !== 64'hBEEF_0000_0000_0000) begin errors++; $display("FAIL sh_wdata got %h exp beef000000000000", mem_wdata); end
    next_cycle();
    mem_ack = 0;
    next_cycle();
  endtask

  task automatic test_misalign();
    drive_nop();
    MemRead_in = 1; RegWrite_in = 1; xfer_size_in = 2; alu_result_in = 64'h102;
    @(negedge clk);
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b exp 1", misalign_err); end
    checks++; if (mem_req !== 1'b0 || stall_mem !== 1'b0 || RegWrite_mem !== 1'b0) begin
      errors++; $display("FAIL mis_resp got req=%b stall=%b rw=%b exp 0 0 0", mem_req, stall_mem, RegWrite_mem); end
    next_cycle();
    drive_nop();
    @(negedge clk);
    checks++; if (misalign_err !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL mis_after got err=%b req=%b exp 0 0", misalign_err, mem_req); end
    next_cycle();
  endtask

  task automatic test_timeout();
    drive_nop();
    MemRead_in = 1; RegWrite_in = 1; xfer_size_in = 3; alu_result_in = 64'h200; mem_rdata = 64'h5555;
    @(negedge clk);
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (bus_err !== (i == 4)) begin errors++; $display("FAIL to_bus_err req cyc %0d got %b exp %b", i, bus_err, (i == 4)); end
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL to_req req cyc %0d got %b exp 1", i, mem_req); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (dm_read_data_mem !== 64'd0 || RegWrite_mem !== 1'b0) begin
      errors++; $display("FAIL to_done got dm=%h rw=%b exp 0 0", dm_read_data_mem, RegWrite_mem); end
    checks++; if (mem_req !== 1'b0 || stall_mem !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL to_done_ctl got req=%b stall=%b err=%b exp 0 0 0", mem_req, stall_mem, bus_err); end
    next_cycle();
    drive_nop(); RegWrite_in = 1;
    @(negedge clk);
    checks++; if (RegWrite_mem !== 1'b1 || stall_mem !== 1'b0) begin errors++; $display("FAIL to_idle got rw=%b stall=%b exp 1 0", RegWrite_mem, stall_mem); end
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    drive_nop();
    MemRead_in = 1; RegWrite_in = 1; xfer_size_in = 3; alu_result_in = 64'h300; mem_rdata = 64'h99;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req got %b exp 1", mem_req); end
    next_cycle();
    reset = 1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall_mem !== 1'b0) begin errors++; $display("FAIL rst_mid_during got req=%b stall=%b exp 0 0", mem_req, stall_mem); end
    next_cycle();
    reset = 0; MemRead_in = 0; mem_ack = 1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall_mem !== 1'b0 || dm_read_data_mem !== 64'd0) begin
      errors++; $display("FAIL rst_late_ack got req=%b stall=%b dm=%h exp 0 0 0", mem_req, stall_mem, dm_read_data_mem); end
    next_cycle();
    mem_ack = 0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || dm_read_data_mem !== 64'd0 || RegWrite_mem !== 1'b1) begin
      errors++; $display("FAIL rst_no_done got req=%b dm=%h rw=%b exp 0 0 1", mem_req, dm_read_data_mem, RegWrite_mem); end
    next_cycle();
  endtask

  initial begin
    reset = 1;
    drive_nop();
    next_cycle();
    test_reset();
    test_alu_passthrough();
    test_load_double();
    test_byte_lanes();
    test_misalign();
    test_timeout();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
